fetch_redirect_ctrl: RTL and testbench

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

---
 rtl/fetch_redirect_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch redirect arbiter/sequencer (RUN -> REDIRECT -> FLUSH)
// Optional redirect counter output enabled by FETCH_REDIRECT_PERF_CNT_EN.
module fetch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ready,
  input  logic        stall_id,
  input  logic        br_valid,
  input  logic [11:0] br_imm,
  input  logic        jal_valid,
  input  logic [19:0] jal_imm,
  input  logic        jalr_valid,
  input  logic [31:0] jalr_target,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic [11:0] imm,
  output logic [19:0] imm_jal,
  output logic [31:0] imm_jalr,
  output logic        flush,
`ifdef FETCH_REDIRECT_PERF_CNT_EN
  output logic [31:0] redirect_cnt,
`endif
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    REDIRECT = 2'b01,
    FLUSH    = 2'b10
  } state_e;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_JAL  = 2'b10;
  localparam logic [1:0] SRC_JALR = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  src_q, src_d;
  logic [11:0] imm_q, imm_d;
  logic [19:0] imm_jal_q, imm_jal_d;
  logic [31:0] imm_jalr_q, imm_jalr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    imm_d      = imm_q;
    imm_jal_d  = imm_jal_q;
    imm_jalr_d = imm_jalr_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b0;
    pc_src     = SRC_SEQ;
    flush      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      RUN: begin
        pc_en = fetch_ready & ~stall_id;
        // Older instruction wins; losing redirects are simply dropped
        if (jalr_valid) begin
          src_d      = SRC_JALR;
          imm_jalr_d = jalr_target;
          state_d    = REDIRECT;
          pc_en      = 1'b0;
        end else if (br_valid) begin
          src_d   = SRC_BR;
          imm_d   = br_imm;
          state_d = REDIRECT;
          pc_en   = 1'b0;
        end else if (jal_valid) begin
          src_d     = SRC_JAL;
          imm_jal_d = jal_imm;
          state_d   = REDIRECT;
          pc_en     = 1'b0;
        end
      end
      REDIRECT: begin
        pc_src = src_q;
        flush  = 1'b1;
        pc_en  = fetch_ready;
        if (fetch_ready) begin
          accept = 1'b1;
          cnt_d  = 3'(FLUSH_CYCLES);
          state_d = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        pc_en = fetch_ready;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      src_q      <= 2'b00;
      imm_q      <= 12'h0;
      imm_jal_q  <= 20'h0;
      imm_jalr_q <= 32'h0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      imm_q      <= imm_d;
      imm_jal_q  <= imm_jal_d;
      imm_jalr_q <= imm_jalr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef FETCH_REDIRECT_PERF_CNT_EN
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) redirect_cnt_q <= 32'h0;
    else if (accept) redirect_cnt_q <= redirect_cnt_q + 32'h1;
  end

  assign redirect_cnt = redirect_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign imm      = imm_q;
  assign imm_jal  = imm_jal_q;
  assign imm_jalr = imm_jalr_q;
  assign state    = state_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, fetch_ready, stall_id;
  logic        br_valid, jal_valid, jalr_valid;
  logic [11:0] br_imm;
  logic [19:0] jal_imm;
  logic [31:0] jalr_target;
  logic        pc_en, flush;
  logic [1:0]  pc_src, state;
  logic [11:0] imm;
  logic [19:0] imm_jal;
  logic [31:0] imm_jalr;
`ifdef FETCH_REDIRECT_PERF_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall_id(stall_id),
    .br_valid(br_valid), .br_imm(br_imm), .jal_valid(jal_valid), .jal_imm(jal_imm),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .pc_en(pc_en), .pc_src(pc_src), .imm(imm), .imm_jal(imm_jal), .imm_jalr(imm_jalr),
    .flush(flush),
`ifdef FETCH_REDIRECT_PERF_CNT_EN
    .redirect_cnt(redirect_cnt),
`endif
    .state(state)
  );

  typedef struct {
    string       tag;
    logic        en;
    logic [1:0]  src;
    logic        fl;
    logic [1:0]  st;
    logic [11:0] imm;
    logic [19:0] ij;
    logic [31:0] ijr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] exp_imm  = '0;
  logic [19:0] exp_jal  = '0;
  logic [31:0] exp_jalr = '0;
  logic [31:0] exp_cnt  = '0;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, ".pc_en"},    32'(pc_en),    32'(e.en));
      check_eq({e.tag, ".pc_src"},   32'(pc_src),   32'(e.src));
      check_eq({e.tag, ".flush"},    32'(flush),    32'(e.fl));
      check_eq({e.tag, ".state"},    32'(state),    32'(e.st));
      check_eq({e.tag, ".imm"},      32'(imm),      32'(e.imm));
      check_eq({e.tag, ".imm_jal"},  32'(imm_jal),  32'(e.ij));
      check_eq({e.tag, ".imm_jalr"}, imm_jalr,      e.ijr);
`ifdef FETCH_REDIRECT_PERF_CNT_EN
      check_eq({e.tag, ".redirect_cnt"}, redirect_cnt, e.cnt);
`endif
    end
  end

  task automatic clr_redirects();
    br_valid = 1'b0; jal_valid = 1'b0; jalr_valid = 1'b0;
  endtask

  // One clock cycle with the current inputs; expectation checked at the negedge
  task automatic cyc(string tag, logic e_en, logic [1:0] e_src, logic e_fl, logic [1:0] e_st);
    sb.push_back('{tag, e_en, e_src, e_fl, e_st, exp_imm, exp_jal, exp_jalr, exp_cnt});
    @(posedge clk);
    if (e_st == 2'b01 && fetch_ready) exp_cnt = exp_cnt + 1;
    #1;
  endtask

  task automatic rst_cyc();
    rst = 1'b1;
    @(posedge clk);
    exp_imm = '0; exp_jal = '0; exp_jalr = '0; exp_cnt = '0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fetch_ready = 1'b1; stall_id = 1'b0;
    br_imm = 12'h0; jal_imm = 20'h0; jalr_target = 32'h0;
    clr_redirects();
    @(posedge clk); #1;
    // Redirects present in the reset cycle must be discarded
    br_valid = 1'b1; br_imm = 12'h5A5; jalr_valid = 1'b1; jalr_target = 32'hDEAD_BEEF;
    rst_cyc();
    clr_redirects();

    for (int i = 0; i < 4; i++) cyc("run_seq", 1'b1, 2'b00, 1'b0, 2'b00);
    stall_id = 1'b1;
    cyc("run_stall", 1'b0, 2'b00, 1'b0, 2'b00);
    stall_id = 1'b0; fetch_ready = 1'b0;
    cyc("run_not_ready", 1'b0, 2'b00, 1'b0, 2'b00);
    fetch_ready = 1'b1;

    // Branch redirect with two flush cycles
    br_valid = 1'b1; br_imm = 12'h010;
    cyc("br_req", 1'b0, 2'b00, 1'b0, 2'b00);
    exp_imm = 12'h010; clr_redirects();
    cyc("br_redir", 1'b1, 2'b01, 1'b1, 2'b01);
    cyc("br_flush1", 1'b1, 2'b00, 1'b1, 2'b10);
    cyc("br_flush2", 1'b1, 2'b00, 1'b1, 2'b10);
    cyc("br_run", 1'b1, 2'b00, 1'b0, 2'b00);

    // All three at once: JALR wins, others untouched
    jalr_valid = 1'b1; jalr_target = 32'h0001_2000;
    br_valid = 1'b1; br_imm = 12'h0AB; jal_valid = 1'b1; jal_imm = 20'h12345;
    cyc("pri_req", 1'b0, 2'b00, 1'b0, 2'b00);
    exp_jalr = 32'h0001_2000; clr_redirects();
    cyc("pri_redir", 1'b1, 2'b11, 1'b1, 2'b01);
    // Flush counts down even with fetch stalled; wrong-path redirects ignored
    fetch_ready = 1'b0; jal_valid = 1'b1; jal_imm = 20'hFFFFF;
    cyc("pri_flush1", 1'b0, 2'b00, 1'b1, 2'b10);
    cyc("pri_flush2", 1'b0, 2'b00, 1'b1, 2'b10);
    clr_redirects(); fetch_ready = 1'b1;
    cyc("pri_run", 1'b1, 2'b00, 1'b0, 2'b00);

    // Branch beats JAL
    br_valid = 1'b1; br_imm = 12'h7FF; jal_valid = 1'b1; jal_imm = 20'h00ABC;
    cyc("bj_req", 1'b0, 2'b00, 1'b0, 2'b00);
    exp_imm = 12'h7FF; clr_redirects();
    cyc("bj_redir", 1'b1, 2'b01, 1'b1, 2'b01);
    cyc("bj_flush1", 1'b1, 2'b00, 1'b1, 2'b10);
    cyc("bj_flush2", 1'b1, 2'b00, 1'b1, 2'b10);

    // JAL held in REDIRECT while fetch is not ready
    jal_valid = 1'b1; jal_imm = 20'h00040; fetch_ready = 1'b0;
    cyc("jal_req", 1'b0, 2'b00, 1'b0, 2'b00);
    exp_jal = 20'h00040; clr_redirects();
    br_valid = 1'b1; br_imm = 12'h3FF;
    for (int i = 0; i < 3; i++) cyc("jal_hold", 1'b0, 2'b10, 1'b1, 2'b01);
    fetch_ready = 1'b1;
    cyc("jal_accept", 1'b1, 2'b10, 1'b1, 2'b01);
    clr_redirects();
    cyc("jal_flush1", 1'b1, 2'b00, 1'b1, 2'b10);
    cyc("jal_flush2", 1'b1, 2'b00, 1'b1, 2'b10);
    stall_id = 1'b1;
    cyc("jal_run_stall", 1'b0, 2'b00, 1'b0, 2'b00);
    stall_id = 1'b0;

    // Reset in the last flush cycle
    br_valid = 1'b1; br_imm = 12'h123;
    cyc("rf_req", 1'b0, 2'b00, 1'b0, 2'b00);
    exp_imm = 12'h123; clr_redirects();
    cyc("rf_redir", 1'b1, 2'b01, 1'b1, 2'b01);
    cyc("rf_flush1", 1'b1, 2'b00, 1'b1, 2'b10);
    rst_cyc();
    cyc("rf_after_rst", 1'b1, 2'b00, 1'b0, 2'b00);
    cyc("rf_after_rst2", 1'b1, 2'b00, 1'b0, 2'b00);

    @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
